// File: rtl/cpu_reset_sequencer.sv
// cpu_reset_sequencer: owns the CPU reset line.
//
// The block holds the core in reset until the PLL is locked, then keeps
// reset asserted for HOLD_CYCLES. It then waits until the serial RX line
// has been idle for RX_IDLE_CYCLES, so that the bootloader never starts in
// the middle of a frame. A user reset request, or a loss of PLL lock,
// restarts the sequence. A saturating counter records how many times the
// core has left RUN.
//
// Ports:
//   clk        in   CPU clock
//   rst_n      in   asynchronous active-low reset of this block
//   pll_locked in   clock wizard lock (asynchronous, synchronized here)
//   rst_req    in   one-cycle reset request pulse (clk-synchronous)
//   serial_rx  in   UART RX pin tap (asynchronous, synchronized here)
//   cpu_rst    out  active-high reset to the core (registered)
//   running    out  high exactly while the state is RUN (registered)
//   state      out  0 WAIT_LOCK, 1 HOLD, 2 WAIT_IDLE, 3 RUN
//   rst_count  out  saturating count of exits from RUN
module cpu_reset_sequencer #(
   parameter int unsigned HOLD_CYCLES    = 16,
   parameter int unsigned RX_IDLE_CYCLES = 5000,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       rst_req,
   input  logic       serial_rx,
   output logic       cpu_rst,
   output logic       running,
   output logic [1:0] state,
   output logic [7:0] rst_count
);

   typedef enum logic [1:0] {
      StWaitLock = 2'd0,
      StHold     = 2'd1,
      StWaitIdle = 2'd2,
      StRun      = 2'd3
   } state_e;

   localparam logic [CNT_WIDTH-1:0] HoldLast = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] IdleLast = CNT_WIDTH'(RX_IDLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [7:0]           rst_count_q, rst_count_d;
   logic                 cpu_rst_q, running_q;

   // Two-flop synchronizers. RX resets high so an idle line is assumed.
   logic locked_meta_q, locked_sync_q;
   logic rx_meta_q, rx_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_meta_q <= 1'b0;
         locked_sync_q <= 1'b0;
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
      end else begin
         locked_meta_q <= pll_locked;
         locked_sync_q <= locked_meta_q;
         rx_meta_q     <= serial_rx;
         rx_sync_q     <= rx_meta_q;
      end
   end

   // Priority inside each state: lock loss, then rst_req, then terminal count.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rst_count_d = rst_count_q;

      case (state_q)
         StWaitLock: begin
            cnt_d = '0;
            if (locked_sync_q) state_d = StHold;
         end
         StHold: begin
            if (!locked_sync_q) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (rst_req) begin
               cnt_d = '0;
            end else if (cnt_q == HoldLast) begin
               state_d = StWaitIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StWaitIdle: begin
            if (!locked_sync_q) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else if (rst_req) begin
               state_d = StHold;
               cnt_d   = '0;
            end else if (!rx_sync_q) begin
               cnt_d = '0;
            end else if (cnt_q == IdleLast) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StRun: begin
            cnt_d = '0;
            if (!locked_sync_q) begin
               state_d = StWaitLock;
            end else if (rst_req) begin
               state_d = StHold;
            end
         end
         default: begin
            state_d = StWaitLock;
            cnt_d   = '0;
         end
      endcase

      if (state_q == StRun && state_d != StRun && rst_count_q != 8'hFF) begin
         rst_count_d = rst_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StWaitLock;
         cnt_q       <= '0;
         rst_count_q <= 8'd0;
         cpu_rst_q   <= 1'b1;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rst_count_q <= rst_count_d;
         // Decoded from the next state so they change on the same edge as state.
         cpu_rst_q   <= (state_d != StRun);
         running_q   <= (state_d == StRun);
      end
   end

   assign cpu_rst   = cpu_rst_q;
   assign running   = running_q;
   assign state     = state_q;
   assign rst_count = rst_count_q;

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Bench for cpu_reset_sequencer with HOLD_CYCLES=4, RX_IDLE_CYCLES=8.
// A timestamp-based model tracks the phase and is compared on every
// falling edge; directed sequences add hand-computed literal checks.
module tb_cpu_reset_sequencer;

   localparam int HOLD = 4;
   localparam int RXI  = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       rst_req;
   logic       serial_rx;
   logic       cpu_rst;
   logic       running;
   logic [1:0] state;
   logic [7:0] rst_count;

   int checks   = 0;
   int failures = 0;

   cpu_reset_sequencer #(
      .HOLD_CYCLES   (HOLD),
      .RX_IDLE_CYCLES(RXI),
      .CNT_WIDTH     (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_locked(pll_locked),
      .rst_req   (rst_req),
      .serial_rx (serial_rx),
      .cpu_rst   (cpu_rst),
      .running   (running),
      .state     (state),
      .rst_count (rst_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase plus the edge numbers at which hold and idle runs began.
   typedef struct {
      int phase;
      int entry;
      int idle_since;
      int exits;
   } mstate_t;

   function automatic mstate_t step(input mstate_t s, input int now, input bit ls,
                                    input bit rs, input bit req);
      mstate_t n = s;
      case (s.phase)
         0: begin
            if (ls) begin
               n.phase = 1;
               n.entry = now;
            end
         end
         1: begin
            if (!ls) n.phase = 0;
            else if (req) n.entry = now;
            else if (now - s.entry == HOLD) begin
               n.phase      = 2;
               n.idle_since = now;
            end
         end
         2: begin
            if (!ls) n.phase = 0;
            else if (req) begin
               n.phase = 1;
               n.entry = now;
            end else if (!rs) n.idle_since = now;
            else if (now - s.idle_since == RXI) n.phase = 3;
         end
         default: begin
            if (!ls) begin
               n.phase = 0;
               n.exits = s.exits + 1;
            end else if (req) begin
               n.phase = 1;
               n.entry = now;
               n.exits = s.exits + 1;
            end
         end
      endcase
      return n;
   endfunction

   mstate_t  m_s;
   int       m_edge;
   bit [1:0] m_lk;  // pin samples of the last two edges, newest in bit 0
   bit [1:0] m_rx;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s    <= '{phase: 0, entry: 0, idle_since: 0, exits: 0};
         m_edge <= 0;
         m_lk   <= 2'b00;
         m_rx   <= 2'b11;
      end else begin
         m_s    <= step(m_s, m_edge + 1, m_lk[1], m_rx[1], rst_req);
         m_edge <= m_edge + 1;
         m_lk   <= {m_lk[0], pll_locked};
         m_rx   <= {m_rx[0], serial_rx};
      end
   end

   always @(negedge clk) begin
      check("model_state", int'(state), m_s.phase);
      check("model_cpu_rst", int'(cpu_rst), (m_s.phase != 3) ? 1 : 0);
      check("model_running", int'(running), (m_s.phase == 3) ? 1 : 0);
      check("model_rst_count", int'(rst_count), (m_s.exits > 255) ? 255 : m_s.exits);
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_req();
      rst_req = 1'b1;
      wait_n(1);
      rst_req = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      rst_req    = 1'b0;
      serial_rx  = 1'b1;
      wait_n(2);
      check("reset_state", int'(state), 0);
      check("reset_cpu_rst", int'(cpu_rst), 1);
      check("reset_running", int'(running), 0);
      check("reset_rst_count", int'(rst_count), 0);
      rst_n = 1'b1;

      // No lock yet: request ignored, stays in WAIT_LOCK.
      wait_n(2);
      pulse_req();
      wait_n(2);
      check("nolock_state", int'(state), 0);

      // Power-up; edge 1 is the first edge sampling pll_locked=1.
      pll_locked = 1'b1;
      wait_n(2);
      check("pu_edge2_state", int'(state), 0);
      wait_n(1);
      check("pu_edge3_state", int'(state), 1);
      wait_n(3);
      check("pu_edge6_state", int'(state), 1);
      wait_n(1);
      check("pu_edge7_state", int'(state), 2);
      wait_n(7);
      check("pu_edge14_cpu_rst", int'(cpu_rst), 1);
      wait_n(1);
      check("pu_edge15_cpu_rst", int'(cpu_rst), 0);
      check("pu_edge15_running", int'(running), 1);
      check("pu_rst_count", int'(rst_count), 0);

      // User reset from RUN (edge E), then RX glitch late in WAIT_IDLE.
      pulse_req();
      check("ur_state", int'(state), 1);
      check("ur_cpu_rst", int'(cpu_rst), 1);
      check("ur_rst_count", int'(rst_count), 1);
      wait_n(4);
      check("ur_wait_idle", int'(state), 2);
      wait_n(5);
      serial_rx = 1'b0;
      wait_n(1);
      serial_rx = 1'b1;
      wait_n(2);
      // Counter would have been terminal here, but rx_sync was low.
      check("rx_no_early_state", int'(state), 2);
      check("rx_no_early_cpu_rst", int'(cpu_rst), 1);
      wait_n(7);
      check("rx_e19_cpu_rst", int'(cpu_rst), 1);
      wait_n(1);
      check("rx_release_running", int'(running), 1);

      // Collision: rst_req on the terminal HOLD cycle restarts the hold.
      pulse_req();
      wait_n(3);
      pulse_req();
      check("col_state", int'(state), 1);
      wait_n(3);
      check("col_hold_again", int'(state), 1);
      wait_n(1);
      check("col_wait_idle", int'(state), 2);
      wait_n(8);
      check("col_running", int'(running), 1);
      check("col_rst_count", int'(rst_count), 2);

      // Lock loss with rst_req seen on the same edge: lock loss wins.
      pll_locked = 1'b0;
      wait_n(2);
      check("ll_still_run", int'(state), 3);
      pulse_req();
      check("ll_state", int'(state), 0);
      check("ll_cpu_rst", int'(cpu_rst), 1);
      check("ll_rst_count", int'(rst_count), 3);
      wait_n(10);
      check("ll_stuck", int'(state), 0);
      pll_locked = 1'b1;
      wait_n(3);
      check("ll_relock_hold", int'(state), 1);
      wait_n(12);
      check("ll_relock_running", int'(running), 1);
      check("ll_count_once", int'(rst_count), 3);

      // Saturation: 300 more exits from RUN.
      for (int i = 0; i < 300; i++) begin
         pulse_req();
         if (i == 250) check("sat_254", int'(rst_count), 254);
         if (i == 251) check("sat_255", int'(rst_count), 255);
         if (i == 252) check("sat_hold", int'(rst_count), 255);
         wait_n(13);
      end
      check("sat_final", int'(rst_count), 255);
      check("sat_running", int'(running), 1);

      // Async reset in WAIT_IDLE, between edges.
      pulse_req();
      wait_n(6);
      check("ar_pre_state", int'(state), 2);
      #2 rst_n = 1'b0;
      #1;
      check("ar_cpu_rst", int'(cpu_rst), 1);
      check("ar_state", int'(state), 0);
      check("ar_rst_count", int'(rst_count), 0);
      wait_n(2);
      rst_n = 1'b1;
      wait_n(3);
      check("ar_relock_hold", int'(state), 1);
      wait_n(12);
      check("ar_running", int'(running), 1);
      check("ar_count", int'(rst_count), 0);

      wait_n(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_reset_sequencer.md
Name: cpu_reset_sequencer

Overview:
- Owns the CPU reset line between the clock wizard, the button parser and the Riscv151 core.
- Holds the core in reset until the PLL reports lock, then stretches reset for a fixed hold time.
- Before releasing the core, waits until the serial RX line has been idle long enough that the bootloader cannot start mid-frame.
- Re-enters the sequence on a user reset request or on loss of PLL lock, and keeps a saturating count of reset events for debug LEDs.

Parameters:
- HOLD_CYCLES, 16: minimum cpu_rst assertion, in clk cycles, after lock or request; must be >= 1.
- RX_IDLE_CYCLES, 5000: consecutive cycles of RX high required before release; must be >= 1.
- CNT_WIDTH, 16: width of the shared internal counter; must hold max(HOLD_CYCLES, RX_IDLE_CYCLES)-1.

Ports:
- clk  input  1  CPU clock (cpu_clk domain).
- rst_n  input  1  asynchronous, active-low reset of this block.
- pll_locked  input  1  clock wizard locked; asynchronous, synchronized internally.
- rst_req  input  1  one-cycle pulse, clk-synchronous (debounced button & switch).
- serial_rx  input  1  FPGA_SERIAL_RX pin tap; asynchronous, synchronized internally.
- cpu_rst  output  1  active-high reset to the core.
- running  output  1  high exactly when the state is RUN.
- state  output  2  encoded state: 0 WAIT_LOCK, 1 HOLD, 2 WAIT_IDLE, 3 RUN.
- rst_count  output  8  saturating count of RUN exits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = WAIT_LOCK, cpu_rst = 1, running = 0, rst_count = 0, counter = 0.
  - Both synchronizers clear: locked_sync = 0, rx_sync = 1.
- Synchronizers: two-flop chains on pll_locked and serial_rx. locked_sync and rx_sync lag their pins by 2 edges.
- Outputs:
  - cpu_rst and running are registered, decoded from the next state.
  - cpu_rst = 0 and running = 1 in exactly the cycles where state == RUN.
- WAIT_LOCK:
  - Counter held at 0.
  - locked_sync == 1 -> HOLD with counter = 0.
- HOLD:
  - Counter increments each cycle.
  - counter == HOLD_CYCLES-1 -> WAIT_IDLE with counter = 0.
  - rst_req in HOLD clears the counter and stays in HOLD (restart the hold).
- WAIT_IDLE:
  - rx_sync == 1 -> counter increments.
  - rx_sync == 0 -> counter cleared.
  - counter == RX_IDLE_CYCLES-1 with rx_sync == 1 -> RUN.
  - rst_req -> HOLD with counter = 0.
- RUN:
  - Counter held at 0.
  - rst_req -> HOLD.
  - rst_count increments on every exit from RUN, saturating at 255.
- Lock loss:
  - locked_sync == 0 in HOLD, WAIT_IDLE or RUN -> WAIT_LOCK with counter = 0.
  - Lock loss has priority over rst_req in the same cycle.
  - Leaving RUN due to lock loss also increments rst_count.
- Simultaneous events: when rst_req coincides with a terminal count in HOLD or WAIT_IDLE, rst_req wins (go to or stay in HOLD, counter = 0).
- rst_req in WAIT_LOCK is ignored.
- Release latency: with serial_rx already high, cpu_rst falls at edge 3 + HOLD_CYCLES + RX_IDLE_CYCLES, counted from the first edge that samples pll_locked = 1.
- Counter arithmetic is unsigned. It never wraps, because every terminal count forces a clear.
- rst_n asserted mid-sequence:
  - cpu_rst rises immediately (asynchronously).
  - rst_count returns to 0.

Test Plan:
- Power-up (HOLD_CYCLES=4, RX_IDLE_CYCLES=8, serial_rx=1): release rst_n, raise pll_locked -> state 1 at edge 3, state 2 at edge 7, cpu_rst falls and running rises at edge 15 (edges counted from the first edge sampling locked); rst_count = 0.
- RX activity: toggle serial_rx low for 1 cycle, 5 cycles into WAIT_IDLE -> counter restarts; release occurs 8 cycles after rx_sync returns high; cpu_rst never drops early.
- User reset: in RUN, pulse rst_req once -> next edge state = 1, cpu_rst = 1, rst_count = 1; release again after 4 + 8 cycles. 300 such pulses -> rst_count saturates at 255.
- Lock loss: drop pll_locked while in RUN with rst_req pulsed the same cycle that locked_sync falls -> state = 0 (not 1), cpu_rst = 1, rst_count +1 once only; no progress until lock returns.
- Collision: rst_req on the terminal HOLD cycle (counter = 3) -> stays in HOLD with counter = 0, four more hold cycles.
- Async reset mid-WAIT_IDLE: assert rst_n low between edges -> cpu_rst = 1, state = 0, rst_count = 0 before the next edge.
